// File: rtl/mvm_result_drain_if.sv
// Stream bundle between the mvm result port, the drain and its downstream consumer.
// Carries the mvm output group (i_valid/i_result) and the serialized element stream
// (o_tdata/o_tvalid/o_tlast with i_tready). slave = drain side, master = environment side.
interface mvm_result_drain_if #(
   parameter int OWIDTH     = 32,
   parameter int NUM_OLANES = 8
);
   logic                     i_valid;
   logic signed [OWIDTH-1:0] i_result [0:NUM_OLANES-1];
   logic signed [OWIDTH-1:0] o_tdata;
   logic                     o_tvalid;
   logic                     i_tready;
   logic                     o_tlast;

   modport slave (
      input  i_valid, i_result, i_tready,
      output o_tdata, o_tvalid, o_tlast
   );

   modport master (
      output i_valid, i_result, i_tready,
      input  o_tdata, o_tvalid, o_tlast
   );
endinterface

// File: rtl/mvm_result_drain.sv
// Captures mvm result groups into a group FIFO and serializes them lane 0 first, one element per beat.
// Latency: a group written at edge t is presented (lane 0) right after edge t; 1 element/cycle sustained.
// Backpressure: i_tready low stalls the stream with outputs held; mvm is never stalled, groups arriving
// while the FIFO is full are dropped and flagged on sticky o_overflow.
// Ports: clk/rst (sync, active-high); i_start/i_num_groups start a run; bus carries mvm groups in and the
// element stream out; o_busy (not idle), o_done (1-cycle end-of-run pulse), o_overflow (group lost).
module mvm_result_drain #(
   parameter int OWIDTH     = 32,
   parameter int NUM_OLANES = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNTW       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [CNTW-1:0]   i_num_groups,
   mvm_result_drain_if.slave bus,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overflow
);
   localparam int LANEW = (NUM_OLANES > 1) ? $clog2(NUM_OLANES) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam logic [LANEW-1:0] LAST_LANE = LANEW'(NUM_OLANES - 1);
   localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNTW-1:0]  num_groups_q, num_groups_d;
   logic [CNTW-1:0]  pushed_cnt_q, pushed_cnt_d;
   logic [CNTW-1:0]  popped_cnt_q, popped_cnt_d;
   logic [CNTW-1:0]  dropped_cnt_q, dropped_cnt_d;
   logic [LANEW-1:0] lane_q, lane_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      fill_q, fill_d;
   logic             overflow_q, overflow_d;

   // Group storage: one row per group, one column per lane. No reset needed,
   // rows are only read while the fill count says they hold data.
   logic signed [OWIDTH-1:0] mem_q [FIFO_DEPTH][NUM_OLANES];

   logic fifo_empty;
   logic fifo_full;
   logic at_last_lane;
   logic beat_hs;
   logic pop;
   logic want_push;
   logic do_push;

   assign fifo_empty   = (fill_q == '0);
   assign fifo_full    = (fill_q == DEPTH_CNT);
   assign at_last_lane = (lane_q == LAST_LANE);
   assign beat_hs      = !fifo_empty && bus.i_tready;
   assign pop          = beat_hs && at_last_lane;
   assign want_push    = (state_q == ST_RUN) && bus.i_valid && (pushed_cnt_q < num_groups_q);

   // Stream outputs depend only on registered state, so they hold through a stall.
   assign bus.o_tvalid = !fifo_empty;
   assign bus.o_tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q][lane_q];
   // Dropped groups never appear on the stream, so they count towards the end of run.
   assign bus.o_tlast  = !fifo_empty && at_last_lane &&
                         ((popped_cnt_q + dropped_cnt_q) == (num_groups_q - CNTW'(1)));
   assign o_overflow   = overflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         num_groups_q  <= '0;
         pushed_cnt_q  <= '0;
         popped_cnt_q  <= '0;
         dropped_cnt_q <= '0;
         lane_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         num_groups_q  <= num_groups_d;
         pushed_cnt_q  <= pushed_cnt_d;
         popped_cnt_q  <= popped_cnt_d;
         dropped_cnt_q <= dropped_cnt_d;
         lane_q        <= lane_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fill_q        <= fill_d;
         overflow_q    <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         for (int l = 0; l < NUM_OLANES; l++) begin
            mem_q[wr_ptr_q][l] <= bus.i_result[l];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      num_groups_d  = num_groups_q;
      pushed_cnt_d  = pushed_cnt_q;
      popped_cnt_d  = popped_cnt_q;
      dropped_cnt_d = dropped_cnt_q;
      lane_d        = lane_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fill_d        = fill_q;
      overflow_d    = overflow_q;
      do_push       = 1'b0;
      o_busy        = (state_q != ST_IDLE);
      o_done        = (state_q == ST_DONE);

      if (i_start) begin
         // Start (or restart) wins over everything else this cycle: flush and relatch.
         num_groups_d  = i_num_groups;
         pushed_cnt_d  = '0;
         popped_cnt_d  = '0;
         dropped_cnt_d = '0;
         lane_d        = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         fill_d        = '0;
         overflow_d    = 1'b0;
         state_d       = (i_num_groups == '0) ? ST_DONE : ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN: begin
               if (beat_hs) begin
                  if (at_last_lane) begin
                     lane_d       = '0;
                     rd_ptr_d     = rd_ptr_q + AW'(1);
                     popped_cnt_d = popped_cnt_q + CNTW'(1);
                  end else begin
                     lane_d = lane_q + LANEW'(1);
                  end
               end
               if (want_push) begin
                  // The counter advances even for a dropped group so the run still ends.
                  pushed_cnt_d = pushed_cnt_q + CNTW'(1);
                  if (!fifo_full || pop) begin
                     do_push  = 1'b1;
                     wr_ptr_d = wr_ptr_q + AW'(1);
                  end else begin
                     dropped_cnt_d = dropped_cnt_q + CNTW'(1);
                     overflow_d    = 1'b1;
                  end
               end
               case ({do_push, pop})
                  2'b10:   fill_d = fill_q + (AW + 1)'(1);
                  2'b01:   fill_d = fill_q - (AW + 1)'(1);
                  default: fill_d = fill_q;
               endcase
               if ((pushed_cnt_d == num_groups_q) && (fill_d == '0)) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mvm_result_drain.sv
`timescale 1ns/1ps
module tb_mvm_result_drain;
   localparam int OW    = 32;
   localparam int NL    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] num_groups;
   logic          busy;
   logic          done;
   logic          ovf;

   mvm_result_drain_if #(.OWIDTH(OW), .NUM_OLANES(NL)) bus();

   mvm_result_drain #(
      .OWIDTH(OW), .NUM_OLANES(NL), .FIFO_DEPTH(DEPTH), .CNTW(CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (start),
      .i_num_groups (num_groups),
      .bus          (bus),
      .o_busy       (busy),
      .o_done       (done),
      .o_overflow   (ovf)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: the run as a list of elements still owed downstream.
   logic signed [OW-1:0] m_elems[$];
   bit                   m_active;
   bit                   m_done;
   bit                   m_ovf;
   int                   m_num;
   int                   m_arrived;

   // Observed accepted beats.
   logic signed [OW-1:0] obs_q[$];
   int                   obs_lasts;
   logic [OW-1:0]        last_dat;

   int rdy_mode = 0;   // 0 hold, 1 always, 2 one-in-three, 3 random
   int rdy_cnt  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      m_elems.delete();
      m_active  = 1'b0;
      m_done    = 1'b0;
      m_ovf     = 1'b0;
      m_num     = 0;
      m_arrived = 0;
   endfunction

   function automatic void obs_clear();
      obs_q.delete();
      obs_lasts = 0;
      last_dat  = '0;
   endfunction

   // One clock: drive tready, compare outputs with model, advance model, step edge.
   task automatic cycle();
      logic [OW-1:0] exp_dat;
      logic [OW-1:0] got_dat;
      bit            pop_grp;
      bit            hs;
      int            occ;
      case (rdy_mode)
         1: bus.i_tready = 1'b1;
         2: begin bus.i_tready = (rdy_cnt % 3 == 0); rdy_cnt++; end
         3: bus.i_tready = 1'($urandom_range(0, 1));
         default: ;
      endcase
      exp_dat = (m_elems.size() > 0) ? m_elems[0] : '0;
      got_dat = bus.o_tdata;
      chk("tvalid",   64'(bus.o_tvalid), 64'(m_elems.size() > 0));
      chk("tdata",    64'(got_dat),      64'(exp_dat));
      chk("tlast",    64'(bus.o_tlast),  64'(m_elems.size() == 1 && m_arrived == m_num));
      chk("busy",     64'(busy),         64'(m_active || m_done));
      chk("done",     64'(done),         64'(m_done));
      chk("overflow", 64'(ovf),          64'(m_ovf));

      if (!rst && !start && bus.o_tvalid && bus.i_tready) begin
         obs_q.push_back(bus.o_tdata);
         if (bus.o_tlast) begin
            obs_lasts++;
            last_dat = bus.o_tdata;
         end
      end

      if (rst) begin
         m_reset();
      end else if (start) begin
         m_elems.delete();
         m_arrived = 0;
         m_ovf     = 1'b0;
         m_num     = int'(num_groups);
         m_active  = (m_num != 0);
         m_done    = (m_num == 0);
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_active) begin
         occ     = (m_elems.size() + NL - 1) / NL;
         hs      = (m_elems.size() > 0) && bus.i_tready;
         pop_grp = hs && (((m_elems.size() - 1) % NL) == 0);
         if (hs) void'(m_elems.pop_front());
         if (bus.i_valid && m_arrived < m_num) begin
            m_arrived++;
            if (occ < DEPTH || pop_grp) begin
               for (int l = 0; l < NL; l++) m_elems.push_back(bus.i_result[l]);
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (m_arrived == m_num && m_elems.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_start(input int n);
      num_groups = CW'(n);
      start      = 1'b1;
      cycle();
      start      = 1'b0;
   endtask

   task automatic push_seq(input int base);
      for (int l = 0; l < NL; l++) bus.i_result[l] = OW'(base + l);
      bus.i_valid = 1'b1;
      cycle();
      bus.i_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (m_active || m_done); i++) cycle();
      chk("drain_busy", 64'(busy), 64'(0));
   endtask

   logic signed [OW-1:0] t4_vals [NL];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      num_groups   = '0;
      bus.i_valid  = 1'b0;
      bus.i_tready = 1'b0;
      for (int l = 0; l < NL; l++) bus.i_result[l] = '0;
      m_reset();
      obs_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle();   // reset state compared against an idle model

      // 1: two groups back-to-back, always ready
      rdy_mode = 1;
      obs_clear();
      do_start(2);
      push_seq(0);
      push_seq(8);
      drain(100);
      chk("t1_beats", 64'(obs_q.size()), 64'(16));
      chk("t1_lasts", 64'(obs_lasts), 64'(1));
      chk("t1_lastdat", 64'(last_dat), 64'(15));
      for (int i = 0; i < obs_q.size(); i++) chk("t1_order", 64'(obs_q[i]), 64'(i));

      // 2: three groups, ready one cycle in three
      rdy_mode = 2;
      rdy_cnt  = 0;
      obs_clear();
      do_start(3);
      push_seq(100);
      push_seq(200);
      push_seq(300);
      drain(300);
      chk("t2_beats", 64'(obs_q.size()), 64'(24));
      chk("t2_ovf", 64'(ovf), 64'(0));
      for (int i = 0; i < obs_q.size(); i++)
         chk("t2_order", 64'(obs_q[i]), 64'(100 * (i / 8 + 1) + (i % 8)));

      // 3: overflow with a stalled consumer
      rdy_mode     = 0;
      bus.i_tready = 1'b0;
      obs_clear();
      do_start(5);
      for (int g = 0; g < 5; g++) push_seq(32 * g);
      chk("t3_ovf_set", 64'(ovf), 64'(1));
      rdy_mode = 1;
      drain(100);
      chk("t3_beats", 64'(obs_q.size()), 64'(32));
      chk("t3_lasts", 64'(obs_lasts), 64'(1));
      chk("t3_lastdat", 64'(last_dat), 64'(3 * 32 + 7));

      // 4: signed extremes pass bit-exact
      t4_vals[0] = 32'hFFFF_FFFF;
      t4_vals[1] = 32'h8000_0000;
      t4_vals[2] = 32'h7FFF_FFFF;
      t4_vals[3] = 32'h0000_0000;
      t4_vals[4] = 32'h0000_0001;
      t4_vals[5] = 32'hFFFF_FF80;
      t4_vals[6] = 32'h0000_007F;
      t4_vals[7] = 32'h0000_0005;
      obs_clear();
      do_start(1);
      for (int l = 0; l < NL; l++) bus.i_result[l] = t4_vals[l];
      bus.i_valid = 1'b1;
      cycle();
      bus.i_valid = 1'b0;
      drain(50);
      chk("t4_beats", 64'(obs_q.size()), 64'(NL));
      for (int i = 0; i < obs_q.size() && i < NL; i++)
         chk("t4_value", 64'(obs_q[i]), 64'(t4_vals[i]));

      // 5: zero-length run, then i_valid while idle
      obs_clear();
      do_start(0);
      chk("t5_done", 64'(done), 64'(1));
      cycle();
      for (int i = 0; i < 4; i++) push_seq(500 + i);
      chk("t5_beats", 64'(obs_q.size()), 64'(0));

      // 6: reset mid-run, then a clean run
      obs_clear();
      do_start(2);
      push_seq(64);
      push_seq(80);
      for (int i = 0; i < 50 && obs_q.size() < 3; i++) cycle();
      chk("t6_beats_before_rst", 64'(obs_q.size()), 64'(3));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t6_rst_tvalid", 64'(bus.o_tvalid), 64'(0));
      chk("t6_rst_tdata", 64'(bus.o_tdata), 64'(0));
      chk("t6_rst_tlast", 64'(bus.o_tlast), 64'(0));
      chk("t6_rst_busy", 64'(busy), 64'(0));
      chk("t6_rst_done", 64'(done), 64'(0));
      chk("t6_rst_ovf", 64'(ovf), 64'(0));
      obs_clear();
      do_start(1);
      push_seq(112);
      drain(50);
      chk("t6_beats", 64'(obs_q.size()), 64'(NL));
      if (obs_q.size() > 0) chk("t6_first", 64'(obs_q[0]), 64'(112));

      // Randomized runs against the model
      for (int r = 0; r < 10; r++) begin
         rdy_mode = (r % 3 == 0) ? 1 : 3;
         do_start($urandom_range(1, 7));
         for (int c = 0; c < 800 && (m_active || m_done); c++) begin
            bus.i_valid = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < NL; l++) bus.i_result[l] = OW'($urandom);
            if (r == 5 && c == 12) begin
               num_groups = CW'($urandom_range(1, 5));
               start      = 1'b1;
            end else begin
               start = 1'b0;
            end
            cycle();
         end
         start       = 1'b0;
         bus.i_valid = 1'b0;
         chk("rand_end_busy", 64'(busy), 64'(0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
